uart_tx_ctrl: RTL

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

---
 rtl/uart_tx_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// =============================================================================
// Module  : uart_tx_ctrl
// Brief   : UART frame transmitter (start, LSB-first data, optional parity,
//           stop). Define UART_TX_TWO_STOP_EN to append a second stop bit.
// Rev     : 1.0
// =============================================================================
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            PRESCALE,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int               BIT_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
`ifdef UART_TX_TWO_STOP_EN
    STOP2  = 3'd5,
`endif
    STOP   = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [5:0]            edge_cnt_q, edge_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  par_typ_q, par_typ_d;
  logic [5:0]            prescale_q, prescale_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;

  logic [5:0]            edge_last;
  logic                  period_end;

  // Unsupported prescale values fall back to 8 edges per bit.
  always_comb begin
    case (prescale_q)
      6'd16:   edge_last = 6'd15;
      6'd32:   edge_last = 6'd31;
      default: edge_last = 6'd7;
    endcase
  end

  assign period_end = (edge_cnt_q == edge_last);

  always_comb begin
    state_d    = state_q;
    edge_cnt_d = edge_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    data_d     = data_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    prescale_d = prescale_q;

    if (state_q == IDLE) begin
      edge_cnt_d = 6'd0;
    end else if (period_end) begin
      edge_cnt_d = 6'd0;
    end else begin
      edge_cnt_d = edge_cnt_q + 6'd1;
    end

    case (state_q)
      IDLE: begin
        if (DATA_VALID) begin
          data_d     = P_DATA;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
          prescale_d = PRESCALE;
          bit_cnt_d  = '0;
          state_d    = START;
        end
      end
      START: begin
        if (period_end) state_d = DATA;
      end
      DATA: begin
        if (period_end) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end
      PARITY: begin
        if (period_end) state_d = STOP;
      end
      STOP: begin
`ifdef UART_TX_TWO_STOP_EN
        if (period_end) state_d = STOP2;
`else
        if (period_end) state_d = IDLE;
`endif
      end
`ifdef UART_TX_TWO_STOP_EN
      STOP2: begin
        if (period_end) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // Line level is decoded from the next state so TX_OUT and BUSY stay registered
  // yet change on the same edge as the FSM.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_d[bit_cnt_d];
      PARITY:  tx_d = (^data_d) ^ par_typ_d;
      default: tx_d = 1'b1;
    endcase
  end

  assign busy_d = (state_d != IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      edge_cnt_q <= 6'd0;
      bit_cnt_q  <= '0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      prescale_q <= 6'd0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      prescale_q <= prescale_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  assign TX_OUT = tx_q;
  assign BUSY   = busy_q;

endmodule
`default_nettype wire
